// File: rtl/down_scale_frame_rx.sv
// Receives the down_scale_valid/down_scale_data pixel stream and writes raster-order frames into a
// two-bank ping-pong BRAM. Optional per-frame pixel checksum when DOWN_SCALE_CHECKSUM_EN is defined.
module down_scale_frame_rx #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              down_scale_valid,
  input  logic [DATA_W-1:0] down_scale_data,
  output logic              bram_we,
  output logic [ADDR_W:0]   bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              frame_done,
  output logic              frame_bank,
  input  logic              rd_release,
  output logic [1:0]        full_cnt,
  output logic              overflow,
  input  logic              ovf_clr,
`ifdef DOWN_SCALE_CHECKSUM_EN
  output logic [DATA_W+ADDR_W-1:0] frame_sum,
`endif
  output logic [15:0]       drop_cnt
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {IDLE, FILL, BLOCKED} state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               wr_bank;
  logic               rel, accept, drop, frame_end, last_col, last_pix;
  logic [1:0]         cnt_rel;
  logic [ADDR_W-1:0]  pix_addr;

  // Banks fill and drain in the same alternating order, so full_cnt alone tells whether
  // wr_bank is free: it is occupied only when both banks are full.
  assign rel      = rd_release && (full_cnt != 2'd0);
  assign cnt_rel  = full_cnt - {1'b0, rel};
  assign last_col = (col == COL_W'(IMG_W - 1));
  assign last_pix = last_col && (row == ROW_W'(IMG_H - 1));
  assign pix_addr = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    drop      = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE, BLOCKED: accept = down_scale_valid && (cnt_rel != 2'd2);
      FILL:          accept = down_scale_valid;
      default:       accept = 1'b0;
    endcase
    drop      = down_scale_valid && !accept;
    frame_end = accept && last_pix;
    if (frame_end)                       state_d = (cnt_rel == 2'd1) ? BLOCKED : IDLE;
    else if (accept)                     state_d = FILL;
    else if (state_q == BLOCKED && rel)  state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      frame_done <= 1'b0;
      frame_bank <= 1'b0;
      full_cnt   <= 2'd0;
      overflow   <= 1'b0;
      drop_cnt   <= 16'd0;
      col        <= '0;
      row        <= '0;
      wr_bank    <= 1'b0;
    end else begin
      bram_we    <= accept;
      frame_done <= frame_end;
      full_cnt   <= cnt_rel + {1'b0, frame_end};
      if (accept) begin
        bram_addr  <= {wr_bank, pix_addr};
        bram_wdata <= down_scale_data;
        if (last_pix) begin
          col <= '0;
          row <= '0;
        end else if (last_col) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (frame_end) begin
        frame_bank <= wr_bank;
        wr_bank    <= ~wr_bank;
      end
      // A drop in the same cycle as a clear restarts the count at this drop.
      if (drop) begin
        overflow <= 1'b1;
        if (ovf_clr)                  drop_cnt <= 16'd1;
        else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
        drop_cnt <= 16'd0;
      end
    end
  end

`ifdef DOWN_SCALE_CHECKSUM_EN
  logic [DATA_W+ADDR_W-1:0] sum_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_acc   <= '0;
      frame_sum <= '0;
    end else if (frame_end) begin
      frame_sum <= sum_acc + (DATA_W+ADDR_W)'(down_scale_data);
      sum_acc   <= '0;
    end else if (accept) begin
      sum_acc   <= sum_acc + (DATA_W+ADDR_W)'(down_scale_data);
    end
  end
`endif

endmodule

// File: tb/tb_down_scale_frame_rx.sv
// Self-checking bench for down_scale_frame_rx: directed frame/overflow/release scenarios followed
// by random traffic, all compared against a queue-free counting model of the frame rules.
module tb_down_scale_frame_rx;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NPIX   = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              down_scale_valid = 1'b0;
  logic [DATA_W-1:0] down_scale_data = '0;
  logic              bram_we;
  logic [ADDR_W:0]   bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic              frame_done;
  logic              frame_bank;
  logic              rd_release = 1'b0;
  logic [1:0]        full_cnt;
  logic              overflow;
  logic              ovf_clr = 1'b0;
  logic [15:0]       drop_cnt;
`ifdef DOWN_SCALE_CHECKSUM_EN
  logic [DATA_W+ADDR_W-1:0] frame_sum;
`endif

  down_scale_frame_rx #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .down_scale_valid(down_scale_valid), .down_scale_data(down_scale_data),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .frame_done(frame_done), .frame_bank(frame_bank),
    .rd_release(rd_release), .full_cnt(full_cnt),
    .overflow(overflow), .ovf_clr(ovf_clr),
`ifdef DOWN_SCALE_CHECKSUM_EN
    .frame_sum(frame_sum),
`endif
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: number of full banks, bank being written, pixel index in current frame.
  int m_full, m_wr, m_pix, m_ovf, m_drop, m_sum, m_fsum;
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_wr = 0; m_pix = 0; m_ovf = 0; m_drop = 0; m_sum = 0; m_fsum = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; down_scale_valid = 1'b0; rd_release = 1'b0; ovf_clr = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check("rst_we", 32'(bram_we), 0);
    check("rst_addr", 32'(bram_addr), 0);
    check("rst_wdata", 32'(bram_wdata), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_bank", 32'(frame_bank), 0);
    check("rst_full", 32'(full_cnt), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_drop", 32'(drop_cnt), 0);
`ifdef DOWN_SCALE_CHECKSUM_EN
    check("rst_sum", 32'(frame_sum), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit rel, input bit clr);
    bit relv, acc, drp, last;
    int exp_addr;
    @(negedge clk);
    down_scale_valid = v; down_scale_data = d; rd_release = rel; ovf_clr = clr;
    // Release is applied first; a new frame may only start into a free bank, a started one always continues.
    relv     = rel && (m_full > 0);
    acc      = v && (m_pix != 0 || (m_full - int'(relv)) < 2);
    drp      = v && !acc;
    last     = acc && (m_pix == NPIX - 1);
    exp_addr = m_wr * (1 << ADDR_W) + m_pix;
    @(posedge clk); #1;
    check("we", 32'(bram_we), 32'(acc));
    if (acc) begin
      check("addr", 32'(bram_addr), exp_addr);
      check("wdata", 32'(bram_wdata), 32'(d));
    end
    check("done", 32'(frame_done), 32'(last));
    if (last) check("frame_bank", 32'(frame_bank), m_wr);
    if (relv) m_full--;
    if (acc) begin
      m_sum += int'(d);
      if (last) begin
        m_fsum = m_sum; m_sum = 0; m_full++; m_wr ^= 1; m_pix = 0;
      end else begin
        m_pix++;
      end
    end
    if (drp) begin
      m_ovf  = 1;
      m_drop = clr ? 1 : ((m_drop < 65535) ? m_drop + 1 : 65535);
    end else if (clr) begin
      m_ovf = 0; m_drop = 0;
    end
    check("full_cnt", 32'(full_cnt), m_full);
    check("overflow", 32'(overflow), m_ovf);
    check("drop_cnt", 32'(drop_cnt), m_drop);
`ifdef DOWN_SCALE_CHECKSUM_EN
    check("frame_sum", 32'(frame_sum), m_fsum);
`endif
    down_scale_valid = 1'b0; rd_release = 1'b0; ovf_clr = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Frame 0 into bank 0, frame 1 into bank 1, then three dropped beats.
    for (int i = 1; i <= 16; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
    check("dir_full2", 32'(full_cnt), 2);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    check("dir_ovf", 32'(overflow), 1);
    check("dir_drop3", 32'(drop_cnt), 3);

    // Release while blocked, refill bank 0, then clear the overflow.
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < NPIX; i++) cycle(1'b1, DATA_W'(i + 40), 1'b0, 1'b0);
    check("dir_refull", 32'(full_cnt), 2);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("dir_clr_ovf", 32'(overflow), 0);
    check("dir_clr_drop", 32'(drop_cnt), 0);

    // Release in the same cycle as the last pixel: count unchanged, next frame accepted.
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < NPIX - 1; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    check("dir_same_full", 32'(full_cnt), 1);
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    check("dir_no_drop", 32'(overflow), 0);

    // Reset mid-frame, then a fresh frame lands in bank 0 from address 0.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < NPIX; i++) cycle(1'b1, 8'hFF, 1'b0, 1'b0);
`ifdef DOWN_SCALE_CHECKSUM_EN
    check("dir_sum_ff", 32'(frame_sum), 2040);
`endif
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < NPIX; i++) cycle(1'b1, 8'h00, 1'b0, 1'b0);
`ifdef DOWN_SCALE_CHECKSUM_EN
    check("dir_sum_zero", 32'(frame_sum), 0);
`endif

    // Random traffic with sparse releases, clears and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle($urandom_range(0, 9) < 7, DATA_W'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
